// File: rtl/riscv_mem_pkg.sv
// Shared memory-port definitions: slot tags, default queue depth, message widths.
// The vc size macros are supplied here when the vc headers are not in the build.
`ifndef VC_MEM_REQ_MSG_SZ
`define VC_MEM_REQ_MSG_SZ(a_, d_) (3 + (a_) + (d_))
`endif
`ifndef VC_MEM_RESP_MSG_SZ
`define VC_MEM_RESP_MSG_SZ(d_) (3 + (d_))
`endif

package riscv_mem_pkg;

  localparam int IMEM_ARB_DEPTH = 4;
  localparam int MEM_REQ_MSG_W  = `VC_MEM_REQ_MSG_SZ(32, 32);
  localparam int MEM_RESP_MSG_W = `VC_MEM_RESP_MSG_SZ(32);

  typedef enum logic {
    SLOT0 = 1'b0,
    SLOT1 = 1'b1
  } slot_tag_e;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/riscv_imem_arb_if.sv
// Bundle of the two core fetch ports, the shared memory port and arbiter status.
// slave = the arbiter; master = the cores and memory around it.
interface riscv_imem_arb_if #(
  parameter int DEPTH = riscv_mem_pkg::IMEM_ARB_DEPTH
);
  import riscv_mem_pkg::*;

  logic [MEM_REQ_MSG_W-1:0]  imemreq0_msg;
  logic                      imemreq0_val;
  logic                      imemreq0_rdy;
  logic [MEM_REQ_MSG_W-1:0]  imemreq1_msg;
  logic                      imemreq1_val;
  logic                      imemreq1_rdy;

  logic [MEM_RESP_MSG_W-1:0] imemresp0_msg;
  logic                      imemresp0_val;
  logic [MEM_RESP_MSG_W-1:0] imemresp1_msg;
  logic                      imemresp1_val;

  logic [MEM_REQ_MSG_W-1:0]  memreq_msg;
  logic                      memreq_val;
  logic                      memreq_rdy;
  logic [MEM_RESP_MSG_W-1:0] memresp_msg;
  logic                      memresp_val;

  logic [cnt_w(DEPTH)-1:0]   outstanding;
  logic                      err;

  modport slave (
    input  imemreq0_msg, imemreq0_val, imemreq1_msg, imemreq1_val,
    output imemreq0_rdy, imemreq1_rdy,
    output imemresp0_msg, imemresp0_val, imemresp1_msg, imemresp1_val,
    output memreq_msg, memreq_val,
    input  memreq_rdy, memresp_msg, memresp_val,
    output outstanding, err
  );

  modport master (
    output imemreq0_msg, imemreq0_val, imemreq1_msg, imemreq1_val,
    input  imemreq0_rdy, imemreq1_rdy,
    input  imemresp0_msg, imemresp0_val, imemresp1_msg, imemresp1_val,
    input  memreq_msg, memreq_val,
    output memreq_rdy, memresp_msg, memresp_val,
    input  outstanding, err
  );

endinterface

// File: rtl/riscv_imem_arb_tagq.sv
// 1-bit-wide tag FIFO recording which slot issued each outstanding request.
// Head is read combinationally so a response can be routed in its arrival cycle.
module riscv_imem_arb_tagq
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = IMEM_ARB_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  slot_tag_e     push_tag_i,
  input  logic          pop_i,
  output slot_tag_e     pop_tag_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  slot_tag_e     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign pop_tag_o = mem_q[rd_ptr_q];
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_tag_i;
  end

endmodule

// File: rtl/riscv_imem_arb.sv
// Two-slot instruction-fetch arbiter onto one in-order memory port.
// Define RISCV_IMEM_ARB_RR_EN for round-robin; default is fixed priority to slot 0.
module riscv_imem_arb
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = IMEM_ARB_DEPTH,
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  riscv_imem_arb_if.slave bus
);

  slot_tag_e     last_grant_q, last_grant_d;
  slot_tag_e     grant;
  slot_tag_e     head_tag;
  logic          err_q, err_d;
  logic          any_val;
  logic          grant0, grant1;
  logic          full, empty;
  logic          fire, pop;
  logic [CW-1:0] count;

  always_comb begin
    grant = SLOT0;
`ifdef RISCV_IMEM_ARB_RR_EN
    if (bus.imemreq0_val && bus.imemreq1_val)
      grant = (last_grant_q == SLOT0) ? SLOT1 : SLOT0;
    else if (bus.imemreq1_val)
      grant = SLOT1;
`else
    if (!bus.imemreq0_val && bus.imemreq1_val)
      grant = SLOT1;
`endif
  end

  assign any_val = bus.imemreq0_val | bus.imemreq1_val;
  assign grant0  = bus.imemreq0_val & (grant == SLOT0);
  assign grant1  = bus.imemreq1_val & (grant == SLOT1);

  // full comes from a register, so a same-cycle response never reopens rdy.
  assign bus.memreq_val   = any_val & ~full & ~reset;
  assign bus.memreq_msg   = (grant == SLOT1) ? bus.imemreq1_msg : bus.imemreq0_msg;
  assign bus.imemreq0_rdy = grant0 & bus.memreq_rdy & ~full & ~reset;
  assign bus.imemreq1_rdy = grant1 & bus.memreq_rdy & ~full & ~reset;
  assign fire             = bus.memreq_val & bus.memreq_rdy;

  assign pop               = bus.memresp_val & ~empty & ~reset;
  assign bus.imemresp0_val = pop & (head_tag == SLOT0);
  assign bus.imemresp1_val = pop & (head_tag == SLOT1);
  assign bus.imemresp0_msg = bus.memresp_msg;
  assign bus.imemresp1_msg = bus.memresp_msg;

  assign bus.outstanding = count;
  assign bus.err         = err_q;

  always_comb begin
    last_grant_d = last_grant_q;
    err_d        = err_q;
    if (fire) last_grant_d = grant;
    if (bus.memresp_val && empty) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= SLOT1;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  riscv_imem_arb_tagq #(
    .DEPTH (DEPTH)
  ) u_tagq (
    .clk        (clk),
    .reset      (reset),
    .push_i     (fire),
    .push_tag_i (grant),
    .pop_i      (pop),
    .pop_tag_o  (head_tag),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count)
  );

endmodule

// File: tb/tb_riscv_imem_arb.sv
// Directed bench for riscv_imem_arb (DEPTH=4): arbitration, ordering, full/empty, reset.
module tb_riscv_imem_arb;
  import riscv_mem_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic exp_tag [4];

  riscv_imem_arb_if #(.DEPTH(DEPTH)) bus ();

  riscv_imem_arb #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [66:0] mk_req(input logic [31:0] addr);
    return {1'b0, addr, 2'b00, 32'h0};
  endfunction

  function automatic logic [34:0] mk_resp(input logic [31:0] data);
    return {1'b0, 2'b00, data};
  endfunction

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [31:0] a0, input logic v1,
                       input logic [31:0] a1, input logic rv, input logic [31:0] rd);
    bus.imemreq0_val = v0;
    bus.imemreq0_msg = mk_req(a0);
    bus.imemreq1_val = v1;
    bus.imemreq1_msg = mk_req(a1);
    bus.memreq_rdy   = 1'b1;
    bus.memresp_val  = rv;
    bus.memresp_msg  = mk_resp(rd);
  endtask

  task automatic chk_resp(input string tag, input logic e0, input logic e1, input logic [31:0] rd);
    chk_b({tag, "_resp0_val"}, bus.imemresp0_val, e0);
    chk_b({tag, "_resp1_val"}, bus.imemresp1_val, e1);
    if (e0) chk_v({tag, "_resp0_msg"}, 67'(bus.imemresp0_msg), 67'(mk_resp(rd)));
    if (e1) chk_v({tag, "_resp1_msg"}, 67'(bus.imemresp1_msg), 67'(mk_resp(rd)));
  endtask

  task automatic chk_out(input string tag, input int n);
    chk_v({tag, "_outstanding"}, 67'(bus.outstanding), 67'(n));
  endtask

  initial begin
    checks = 0;
    errors = 0;
`ifdef RISCV_IMEM_ARB_RR_EN
    exp_tag = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_tag = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    // Reset with all inputs active: outputs must stay quiet.
    reset = 1'b1;
    drive(1'b1, 32'h0, 1'b1, 32'h4, 1'b1, 32'h0);
    #3;
    chk_out("rst", 0);
    chk_b("rst_err", bus.err, 1'b0);
    chk_b("rst_memreq_val", bus.memreq_val, 1'b0);
    chk_b("rst_rdy0", bus.imemreq0_rdy, 1'b0);
    chk_b("rst_rdy1", bus.imemreq1_rdy, 1'b0);
    chk_resp("rst", 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    reset = 1'b0;

    // Both slots valid for four cycles: grant pattern, then the queue is full.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h1000 + 32'(i * 8), 1'b1, 32'h2000 + 32'(i * 8), 1'b0, 32'h0);
      #1;
      chk_b($sformatf("arb%0d_rdy0", i), bus.imemreq0_rdy, exp_tag[i] == 1'b0);
      chk_b($sformatf("arb%0d_rdy1", i), bus.imemreq1_rdy, exp_tag[i] == 1'b1);
      chk_v($sformatf("arb%0d_msg", i), bus.memreq_msg,
            exp_tag[i] ? mk_req(32'h2000 + 32'(i * 8)) : mk_req(32'h1000 + 32'(i * 8)));
      @(posedge clk); #1;
      chk_out($sformatf("arb%0d", i), i + 1);
    end

    @(negedge clk);
    drive(1'b1, 32'h3000, 1'b1, 32'h3004, 1'b0, 32'h0);
    #1;
    chk_b("full_memreq_val", bus.memreq_val, 1'b0);
    chk_b("full_rdy0", bus.imemreq0_rdy, 1'b0);
    chk_b("full_rdy1", bus.imemreq1_rdy, 1'b0);
    @(posedge clk); #1;
    chk_out("full", 4);

    // Response while full and requesting: no fire, one pop.
    @(negedge clk);
    drive(1'b1, 32'h3000, 1'b1, 32'h3004, 1'b1, 32'hD000);
    #1;
    chk_b("fullpop_memreq_val", bus.memreq_val, 1'b0);
    chk_b("fullpop_rdy0", bus.imemreq0_rdy, 1'b0);
    chk_b("fullpop_rdy1", bus.imemreq1_rdy, 1'b0);
    chk_resp("fullpop", exp_tag[0] == 1'b0, exp_tag[0] == 1'b1, 32'hD000);
    @(posedge clk); #1;
    chk_out("fullpop", 3);

    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hD000 + 32'(i));
      #1;
      chk_resp($sformatf("drain%0d", i), exp_tag[i] == 1'b0, exp_tag[i] == 1'b1, 32'hD000 + 32'(i));
      @(posedge clk); #1;
      chk_out($sformatf("drain%0d", i), 3 - i);
    end

    // Ordering: slot1 @0x100 then slot0 @0x104.
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0);
    #1;
    chk_b("ord_a_rdy1", bus.imemreq1_rdy, 1'b1);
    chk_b("ord_a_rdy0", bus.imemreq0_rdy, 1'b0);
    chk_v("ord_a_msg", bus.memreq_msg, mk_req(32'h100));
    @(negedge clk);
    drive(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk_b("ord_b_rdy0", bus.imemreq0_rdy, 1'b1);
    chk_v("ord_b_msg", bus.memreq_msg, mk_req(32'h104));
    @(posedge clk); #1;
    chk_out("ord_fired", 2);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hAAAA);
    #1;
    chk_resp("ord_r1", 1'b0, 1'b1, 32'hAAAA);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hBBBB);
    #1;
    chk_resp("ord_r2", 1'b1, 1'b0, 32'hBBBB);
    @(posedge clk); #1;
    chk_out("ord_done", 0);

    // Simultaneous push and pop at outstanding=2: queue [0,1] -> [1,0].
    @(negedge clk);
    drive(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 32'h204, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk_out("pp_pre", 2);
    @(negedge clk);
    drive(1'b1, 32'h208, 1'b0, 32'h0, 1'b1, 32'hC001);
    #1;
    chk_b("pp_rdy0", bus.imemreq0_rdy, 1'b1);
    chk_resp("pp", 1'b1, 1'b0, 32'hC001);
    @(posedge clk); #1;
    chk_out("pp", 2);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hC002);
    #1;
    chk_resp("pp_d1", 1'b0, 1'b1, 32'hC002);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hC003);
    #1;
    chk_resp("pp_d2", 1'b1, 1'b0, 32'hC003);
    @(posedge clk); #1;
    chk_out("pp_done", 0);
    chk_b("pp_err", bus.err, 1'b0);

    // Stray response on an empty queue: sticky err.
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hE000);
    #1;
    chk_resp("stray", 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk_b("stray_err", bus.err, 1'b1);
    chk_out("stray", 0);
    @(negedge clk);
    drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hE001);
    #1;
    chk_resp("after_stray", 1'b1, 1'b0, 32'hE001);
    @(posedge clk); #1;
    chk_b("stray_err_sticky", bus.err, 1'b1);

    // Asynchronous reset with three tags outstanding.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h400 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 32'h0);
    end
    @(posedge clk); #1;
    chk_out("ar_pre", 3);
    @(negedge clk);
    drive(1'b1, 32'h40C, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk_out("ar", 0);
    chk_b("ar_err", bus.err, 1'b0);
    chk_b("ar_memreq_val", bus.memreq_val, 1'b0);
    chk_b("ar_rdy0", bus.imemreq0_rdy, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hF000);
    #1;
    chk_resp("ar_stray", 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk_b("ar_stray_err", bus.err, 1'b1);
    chk_out("ar_stray", 0);

    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
